seg_mux_drv: RTL and testbench
==============================

SEG_MUX_DRV -- requirements
Module: seg_mux_drv

Interface
REQ-001 Parameter DIGITS, default 4, number of multiplexed digits; legal range 1..8.
REQ-002 Parameter REFRESH_DIV, default 50000, clocks per digit slot; legal range 4..2^20.
REQ-003 Parameter DEAD, default 16, anti-ghost blank clocks at the start of each slot; legal range 0..REFRESH_DIV-1.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 load  in  1  single-cycle request to capture digits_in and blank_mask.
REQ-007 digits_in  in  4*DIGITS  hex nibbles; nibble 0 (bits 3:0) is the rightmost digit.
REQ-008 blank_mask  in  DIGITS  1 = force that digit dark.
REQ-009 seg  out  7  segments {a,b,c,d,e,f,g}, a = bit 6, active-low (0 = lit).
REQ-010 an  out  DIGITS  digit enables, active-low, at most one low at a time.
REQ-011 frame_strobe  out  1  one-cycle pulse marking a frame boundary.

Function
REQ-012 A prescaler cnt counts 0..REFRESH_DIV-1 and wraps; a digit index idx (width max(1,$clog2(DIGITS))) advances on cnt wrap, from DIGITS-1 back to 0.
REQ-013 A frame boundary is the cycle in which cnt==REFRESH_DIV-1 and idx==DIGITS-1; for DIGITS=1 it occurs on every cnt wrap.
REQ-014 The block is double-buffered: load=1 writes digits_in/blank_mask into a pending buffer and sets pending_valid; a later load overwrites pending.
REQ-015 At each frame boundary, if pending_valid=1, pending is copied into the active buffer, active_valid is set, and pending_valid is cleared; the active buffer changes at no other time.
REQ-016 If load=1 coincides with a frame boundary, digits_in/blank_mask go directly to active, and pending_valid ends up 0.
REQ-017 The decode table for seg is: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
REQ-018 seg is 1111111 when active_valid=0, or when the active blank_mask bit for idx is 1, or when the digit is suppressed per REQ-024.
REQ-019 While cnt<DEAD, an is all ones; otherwise an[idx]=0 and all other bits are 1.
REQ-020 seg, an and frame_strobe are registered and reflect the cnt/idx/active state of the previous cycle, i.e. one clock of latency.
REQ-021 frame_strobe is 1 for exactly the one cycle following each frame boundary, including boundaries with no pending data.
REQ-022 A load while pending_valid=1 is never lost; the last load before a boundary wins.

Reset
REQ-023 While rst_n=0, asynchronously: cnt=0, idx=0, pending_valid=0, active_valid=0, both buffers cleared, seg=1111111, an=all ones, frame_strobe=0; after release, scanning restarts from digit 0 with cnt=0, and any load issued before the reset is discarded.

Configuration
REQ-024 With SEG_LEADING_ZERO_BLANK_EN defined, active digits whose value is 0 are dark, counting from DIGITS-1 downward until the first nonzero digit; digit 0 is never suppressed by this rule.
REQ-025 Without SEG_LEADING_ZERO_BLANK_EN, every unmasked active digit is decoded, including leading zeros; there is no port difference between the two builds.

Verification
All scenarios use DIGITS=4, REFRESH_DIV=8, DEAD=2 unless stated.
REQ-026 Reset, then load digits_in=16'h1A3F, blank_mask=0 at cycle 2 -> seg stays 1111111 through the first frame; frame_strobe pulses once every 32 clocks; from the next frame, digit 0 shows 0111000 (F) and digit 3 shows 1001111 (1).
REQ-027 Steady scan -> an follows the sequence 1111 (2 clocks), 1110 (6 clocks), 1111, 1101, and so on, with never more than one bit low.
REQ-028 Load 16'h0000 then 16'h5555 within the same frame -> only 0100100 (5) is ever displayed; 0000001 never appears.
REQ-029 Load 16'hC0DE coincident with a frame boundary -> C0DE is displayed in the frame starting there; pending_valid=0 afterwards.
REQ-030 blank_mask=4'b0100 with 16'h8888 -> digit 2 slot shows seg=1111111 while an[2]=0; other digits show 0000000.
REQ-031 Build with SEG_LEADING_ZERO_BLANK_EN and load 16'h0070 -> digits 3 and 2 are dark, digit 1 shows 7 (0001111), digit 0 shows 0 (0000001); assert rst_n=0 mid-slot -> seg=1111111 and an=1111 immediately, with no clock required.

Source files
------------

// File: rtl/seg_mux_drv_if.sv
// Bus bundle for seg_mux_drv: digit load request in, multiplexed segment/anode drive out.
// The controller side uses the master modport; the display driver uses the slave modport.
interface seg_mux_drv_if #(
    parameter int DIGITS = 4
);
    logic                  load;
    logic [4*DIGITS-1:0]   digits_in;
    logic [DIGITS-1:0]     blank_mask;
    logic [6:0]            seg;
    logic [DIGITS-1:0]     an;
    logic                  frame_strobe;

    modport master (
        output load, digits_in, blank_mask,
        input  seg, an, frame_strobe
    );

    modport slave (
        input  load, digits_in, blank_mask,
        output seg, an, frame_strobe
    );
endinterface

// File: rtl/seg_mux_drv.sv
// Multiplexed 7-segment driver with double-buffered digit load and anti-ghost dead time.
// Optional build macro SEG_LEADING_ZERO_BLANK_EN darkens leading zero digits.
module seg_mux_drv #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int DEAD        = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    seg_mux_drv_if.slave  bus
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_DEAD = CNT_W'(DEAD);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic [CNT_W-1:0]      r_cnt;
    logic [IDX_W-1:0]      r_idx;

    logic [4*DIGITS-1:0]   r_pend_digits;
    logic [DIGITS-1:0]     r_pend_mask;
    logic                  r_pend_valid;
    logic [4*DIGITS-1:0]   r_act_digits;
    logic [DIGITS-1:0]     r_act_mask;
    logic                  r_act_valid;

    logic [6:0]            r_seg;
    logic [DIGITS-1:0]     r_an;
    logic                  r_strobe;

    logic                  w_cnt_wrap;
    logic                  w_frame;
    logic [3:0]            w_nibble;
    logic                  w_blank;
    logic                  w_supp;
    logic [DIGITS-1:0]     w_lz;
    logic [6:0]            w_seg_next;
    logic [DIGITS-1:0]     w_an_next;

    function automatic logic [6:0] decodeHex(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    assign w_cnt_wrap = (r_cnt == CNT_LAST);
    assign w_frame    = w_cnt_wrap && (r_idx == IDX_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (w_cnt_wrap) begin
            r_cnt <= '0;
            r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // A load landing on the frame boundary bypasses pending so it is shown in the frame that starts next.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_digits <= '0;
            r_pend_mask   <= '0;
            r_pend_valid  <= 1'b0;
            r_act_digits  <= '0;
            r_act_mask    <= '0;
            r_act_valid   <= 1'b0;
        end else if (w_frame) begin
            if (bus.load) begin
                r_act_digits <= bus.digits_in;
                r_act_mask   <= bus.blank_mask;
                r_act_valid  <= 1'b1;
            end else if (r_pend_valid) begin
                r_act_digits <= r_pend_digits;
                r_act_mask   <= r_pend_mask;
                r_act_valid  <= 1'b1;
            end
            r_pend_valid <= 1'b0;
        end else if (bus.load) begin
            r_pend_digits <= bus.digits_in;
            r_pend_mask   <= bus.blank_mask;
            r_pend_valid  <= 1'b1;
        end
    end

`ifdef SEG_LEADING_ZERO_BLANK_EN
    logic w_still_zero;

    // Walk down from the top digit; suppression stops at the first nonzero digit and never reaches digit 0.
    always_comb begin
        w_lz         = '0;
        w_still_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (w_still_zero && (r_act_digits[i*4 +: 4] == 4'h0)) begin
                w_lz[i] = 1'b1;
            end else begin
                w_still_zero = 1'b0;
            end
        end
    end
`else
    assign w_lz = '0;
`endif

    always_comb begin
        w_nibble = 4'h0;
        w_blank  = 1'b0;
        w_supp   = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_nibble = r_act_digits[i*4 +: 4];
                w_blank  = r_act_mask[i];
                w_supp   = w_lz[i];
            end
        end
    end

    always_comb begin
        w_seg_next = 7'b1111111;
        w_an_next  = '1;
        if (r_act_valid && !w_blank && !w_supp) begin
            w_seg_next = decodeHex(w_nibble);
        end
        if (r_cnt >= CNT_DEAD) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (r_idx == IDX_W'(i)) begin
                    w_an_next[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg    <= 7'b1111111;
            r_an     <= '1;
            r_strobe <= 1'b0;
        end else begin
            r_seg    <= w_seg_next;
            r_an     <= w_an_next;
            r_strobe <= w_frame;
        end
    end

    assign bus.seg          = r_seg;
    assign bus.an           = r_an;
    assign bus.frame_strobe = r_strobe;

endmodule

// File: tb/tb_seg_mux_drv.sv
// Directed bench for seg_mux_drv (DIGITS=4, REFRESH_DIV=8, DEAD=2); frames are 32 clocks.
// Compile with SEG_LEADING_ZERO_BLANK_EN defined to check the leading-zero build.
module tb_seg_mux_drv;

    localparam int DIGITS      = 4;
    localparam int REFRESH_DIV = 8;
    localparam int DEAD        = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    seg_mux_drv_if #(.DIGITS(DIGITS)) bus ();

    seg_mux_drv #(
        .DIGITS      (DIGITS),
        .REFRESH_DIV (REFRESH_DIV),
        .DEAD        (DEAD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0]     digits;
        logic [3:0]      mask;
        logic [3:0][6:0] exp;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
        end
    endtask

    // Holds load high for exactly one clock starting at the current negedge.
    task automatic applyStimulus(input logic [15:0] d, input logic [3:0] m);
        bus.load       = 1'b1;
        bus.digits_in  = d;
        bus.blank_mask = m;
        @(negedge clk);
        bus.load = 1'b0;
    endtask

    task automatic waitStrobe(input string name);
        int n = 0;
        while (bus.frame_strobe !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            total++;
            bad++;
            $display("[TB] FAIL %s: actual=no_strobe required=strobe", name);
        end
    endtask

    // Called on the negedge where frame_strobe is high; samples each digit mid-slot.
    task automatic checkFrame(input logic [3:0][6:0] exp, input string tag);
        int pos;
        logic [3:0] anExp;
        @(negedge clk);
        pos = 1;
        checkOutput({tag, "_deadAn"}, 16'(bus.an), 16'hF);
        checkOutput({tag, "_strobeLow"}, 16'(bus.frame_strobe), 16'h0);
        for (int d = 0; d < 4; d++) begin
            while (pos < 8 * d + 5) begin
                @(negedge clk);
                pos++;
            end
            anExp = ~(4'b0001 << d);
            checkOutput($sformatf("%s_an%0d", tag, d), 16'(bus.an), 16'(anExp));
            checkOutput($sformatf("%s_seg%0d", tag, d), 16'(bus.seg), 16'(exp[d]));
        end
    endtask

    // First frame after reset release: display dark, an scan pattern, single strobe at clock 32.
    task automatic checkColdFrame(input logic doLoad, input string tag);
        int darkErr = 0;
        int anErr   = 0;
        int hotErr  = 0;
        int strbErr = 0;
        logic [3:0] anExp;
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            if (bus.seg !== 7'b1111111) darkErr++;
            anExp = (((k - 1) % 8) < DEAD) ? 4'hF : ~(4'b0001 << ((k - 1) / 8));
            if (bus.an !== anExp) anErr++;
            if (!$onehot0(~bus.an)) hotErr++;
            if (bus.frame_strobe !== ((k == 32) ? 1'b1 : 1'b0)) strbErr++;
            if (doLoad && k == 2) begin
                bus.load       = 1'b1;
                bus.digits_in  = 16'h1A3F;
                bus.blank_mask = 4'b0000;
            end else begin
                bus.load = 1'b0;
            end
        end
        checkOutput({tag, "_darkErrors"}, 16'(darkErr), 16'd0);
        checkOutput({tag, "_anSeqErrors"}, 16'(anErr), 16'd0);
        checkOutput({tag, "_multiLowErrors"}, 16'(hotErr), 16'd0);
        checkOutput({tag, "_strobeErrors"}, 16'(strbErr), 16'd0);
    endtask

    initial begin
        int zeroSeen;
        int n;

        vecs[0] = '{16'h8888, 4'b0100, {7'h00, 7'h7F, 7'h00, 7'h00}};
        vecs[1] = '{16'h2469, 4'b0000, {7'h12, 7'h4C, 7'h20, 7'h04}};
        vecs[2] = '{16'h7B5E, 4'b1001, {7'h7F, 7'h60, 7'h24, 7'h7F}};
        vecs[3] = '{16'hCD80, 4'b0000, {7'h31, 7'h42, 7'h00, 7'h01}};
`ifdef SEG_LEADING_ZERO_BLANK_EN
        vecs[4] = '{16'h0070, 4'b0000, {7'h7F, 7'h7F, 7'h0F, 7'h01}};
        vecs[5] = '{16'h0000, 4'b0000, {7'h7F, 7'h7F, 7'h7F, 7'h01}};
        vecs[6] = '{16'h0F00, 4'b0001, {7'h7F, 7'h38, 7'h01, 7'h7F}};
`else
        vecs[4] = '{16'h0070, 4'b0000, {7'h01, 7'h01, 7'h0F, 7'h01}};
        vecs[5] = '{16'h0000, 4'b0000, {7'h01, 7'h01, 7'h01, 7'h01}};
        vecs[6] = '{16'h0F00, 4'b0001, {7'h01, 7'h38, 7'h01, 7'h7F}};
`endif
        vecs[7] = '{16'hE91F, 4'b0000, {7'h30, 7'h04, 7'h4F, 7'h38}};

        bus.load       = 1'b0;
        bus.digits_in  = 16'h0;
        bus.blank_mask = 4'h0;
        rst_n          = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("resetSeg", 16'(bus.seg), 16'h7F);
        checkOutput("resetAn", 16'(bus.an), 16'hF);
        checkOutput("resetStrobe", 16'(bus.frame_strobe), 16'h0);
        rst_n = 1'b1;

        checkColdFrame(1'b1, "cold");
        checkFrame({7'h4F, 7'h08, 7'h06, 7'h38}, "v1A3F");

        for (int v = 0; v < 8; v++) begin
            waitStrobe($sformatf("vec%0d_strobeA", v));
            applyStimulus(vecs[v].digits, vecs[v].mask);
            waitStrobe($sformatf("vec%0d_strobeB", v));
            checkFrame(vecs[v].exp, $sformatf("vec%0d", v));
        end

        // Two loads within one frame: only the later value may ever reach the display.
        waitStrobe("lastWins_strobeA");
        applyStimulus(16'h0000, 4'b0000);
        repeat (3) @(negedge clk);
        applyStimulus(16'h5555, 4'b0000);
        zeroSeen = 0;
        n        = 0;
        while (bus.frame_strobe !== 1'b1 && n < 40) begin
            @(negedge clk);
            if (bus.seg === 7'b0000001) zeroSeen++;
            n++;
        end
        checkOutput("lastWins_strobeFound", 16'(n < 40), 16'h1);
        checkFrame({7'h24, 7'h24, 7'h24, 7'h24}, "lastWins");
        checkOutput("lastWins_zeroSeen", 16'(zeroSeen), 16'h0);

        // Load exactly on the boundary clock goes straight to the frame that starts next.
        waitStrobe("bnd_strobeA");
        repeat (31) @(negedge clk);
        applyStimulus(16'hC0DE, 4'b0000);
        checkOutput("bnd_strobeNow", 16'(bus.frame_strobe), 16'h1);
        checkFrame({7'h31, 7'h01, 7'h42, 7'h30}, "bndC0DE");
        waitStrobe("bnd_strobeB");
        checkFrame({7'h31, 7'h01, 7'h42, 7'h30}, "bndHold");

        // Asynchronous reset mid-slot with a pending load that must be discarded.
        waitStrobe("rst_strobeA");
        applyStimulus(16'h2469, 4'b0000);
        repeat (4) @(negedge clk);
        checkOutput("rst_preAn", 16'(bus.an), 16'hE);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_asyncSeg", 16'(bus.seg), 16'h7F);
        checkOutput("rst_asyncAn", 16'(bus.an), 16'hF);
        checkOutput("rst_asyncStrobe", 16'(bus.frame_strobe), 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        checkColdFrame(1'b0, "postRst");
        checkFrame({7'h7F, 7'h7F, 7'h7F, 7'h7F}, "postRstDark");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
